dmem_responder: RTL

Data-memory responder for the Y86-64 pipeline. The memory stage issues one word-sized load or store over a valid/ready request channel. This block serves the access from a word-addressed 64-bit array after a fixed, parameterised latency. It returns read data and a bounds error on a one-cycle response pulse, and drives a stall to pipeline control while the access is in flight.

---
 rtl/y86_mem_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_array.sv | 48 ++++
 rtl/dmem_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 data-memory path: responder FSM states,
// default memory depth and the icodes the memory stage uses to pick loads/stores.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  localparam int DMEM_DEPTH = 1024;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Stores are the instructions that push a value out to memory.
  function automatic logic icode_is_store(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage (master) and the
// data-memory responder (slave), plus the stall it returns to pipeline control.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        mem_stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_stall
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous 64-bit RAM with registered read. The read register
// returns zero for stores and for cleared (error) responses.
module dmem_array
  import y86_mem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_q, rdata_d;

  // NOTE: storage has no reset so it maps onto RAM; only the read register resets.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = we ? 64'd0 : mem[addr];
    end else if (clr) begin
      rdata_d = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 64'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, serves it from dmem_array after
// LATENCY cycles (or flags an out-of-range address at once) and stalls M/W meanwhile.
module dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_error_q, resp_error_d;

  logic          in_range;
  logic          arr_en, arr_we, arr_clr;
  logic [AW-1:0] arr_addr;
  logic [63:0]   arr_wdata, arr_rdata;

  // Full 64-bit compare so stray upper address bits can never alias into the array.
  assign in_range = bus.req_addr < 64'(DEPTH);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    arr_en       = 1'b0;
    arr_we       = write_q;
    arr_clr      = 1'b0;
    arr_addr     = addr_q;
    arr_wdata    = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr[AW-1:0];
          wdata_d = bus.req_wdata;
          if (!in_range) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            arr_clr      = 1'b1;
          end else if (LATENCY == 1) begin
            // Commit straight from the bus: the latched copies are not yet valid.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            arr_en       = 1'b1;
            arr_we       = bus.req_write;
            arr_addr     = bus.req_addr[AW-1:0];
            arr_wdata    = bus.req_wdata;
          end else begin
            cnt_d   = CW'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          arr_en       = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset landing on the commit edge drops the access, including its write.
    if (rst) begin
      arr_en = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .we    (arr_we),
    .clr   (arr_clr),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_stall  = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_rdata = arr_rdata;

endmodule
